// File: rtl/ex_wb_reg_pkg.sv
// Shared types for the execute-to-writeback register: widths, occupancy state, entry layout.
// Included by the skid FIFO and the ex_wb_reg top.
package ex_wb_reg_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int REGISTER  = 6;
    localparam int DEPTH     = 2;

    // Occupancy doubles as the FIFO state; the encoding is the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [REGISTER-1:0]  write_reg;
        logic [BUS_WIDTH-1:0] result;
    } entry_t;

    function automatic logic occ_has_room(input occ_e occ);
        return occ != OCC_FULL;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Generic 2-entry FIFO with flush; head entry and valid are registered outputs.
// Push in FULL is ignored; the caller gates push with room so no ready-from-pop path exists.
module wb_fifo2 #(
    parameter type T = ex_wb_reg_pkg::entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  logic pop,
    input  logic flush,
    input  T     push_dat,
    output T     head_dat,
    output logic head_vld,
    output ex_wb_reg_pkg::occ_e count
);
    import ex_wb_reg_pkg::*;

    occ_e occ_q, occ_d;
    T     head_q, head_d;
    T     tail_q, tail_d;
    logic vld_q, vld_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            // Storage keeps stale data; only the count is dropped.
            occ_d = OCC_EMPTY;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (push_vld) begin
                        head_d = push_dat;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push_vld && pop) begin
                        head_d = push_dat;
                    end else if (push_vld) begin
                        tail_d = push_dat;
                        occ_d  = OCC_FULL;
                    end else if (pop) begin
                        occ_d  = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_d = tail_q;
                        occ_d  = OCC_ONE;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
        vld_d = (occ_d != OCC_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            vld_q  <= vld_d;
        end
    end

    assign head_dat = head_q;
    assign head_vld = vld_q;
    assign count    = occ_q;

endmodule

// File: rtl/ex_wb_reg.sv
// Execute-to-writeback register: selects writeback data/destination and skids up to two results.
// One cycle E-to-W latency; ReadyE drops when two entries are held, independent of ReadyW.
module ex_wb_reg #(
    parameter int BUS_WIDTH = ex_wb_reg_pkg::BUS_WIDTH,
    parameter int REGISTER  = ex_wb_reg_pkg::REGISTER,
    parameter int DEPTH     = ex_wb_reg_pkg::DEPTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ValidE,
    output logic                 ReadyE,
    input  logic                 FlushE,
    input  logic                 RegWriteE,
    input  logic                 MemtoRegE,
    input  logic                 RegDstE,
    input  logic [REGISTER-1:0]  RtE,
    input  logic [REGISTER-1:0]  RdE,
    input  logic [BUS_WIDTH-1:0] ALUOutE,
    input  logic [BUS_WIDTH-1:0] ReadDataE,
    output logic                 ValidW,
    input  logic                 ReadyW,
    output logic [REGISTER-1:0]  WriteRegW,
    output logic [BUS_WIDTH-1:0] ResultW,
    output logic [1:0]           Occupancy
);
    import ex_wb_reg_pkg::*;

    typedef struct packed {
        logic [REGISTER-1:0]  write_reg;
        logic [BUS_WIDTH-1:0] result;
    } wb_entry_t;

    occ_e      fifo_count;
    wb_entry_t fifo_head;
    wb_entry_t cap_dat;
    logic      fifo_vld;
    logic      ready_e;
    logic      accept;
    logic      push_vld;
    logic      pop;

    // Ready comes only from registered occupancy, so a same-cycle pop in FULL cannot admit a push.
    assign ready_e  = (int'(fifo_count) < DEPTH) && occ_has_room(fifo_count) && !RST;
    assign accept   = ValidE && ready_e && !FlushE;
    // Non-writing results complete the handshake but occupy no slot.
    assign push_vld = accept && RegWriteE;
    assign pop      = fifo_vld && ReadyW;

    always_comb begin
        cap_dat.write_reg = RegDstE   ? RdE       : RtE;
        cap_dat.result    = MemtoRegE ? ReadDataE : ALUOutE;
    end

    wb_fifo2 #(
        .T(wb_entry_t)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push_vld (push_vld),
        .pop      (pop),
        .flush    (FlushE),
        .push_dat (cap_dat),
        .head_dat (fifo_head),
        .head_vld (fifo_vld),
        .count    (fifo_count)
    );

    assign ReadyE    = ready_e;
    assign ValidW    = fifo_vld;
    assign WriteRegW = fifo_head.write_reg;
    assign ResultW   = fifo_head.result;
    assign Occupancy = fifo_count;

endmodule

// File: doc/ex_wb_reg.md
# ex_wb_reg

Execute-to-writeback pipeline register for the NN simulator core: the downstream end of the decode/execute register path. Captures execute-stage results, selects writeback data and destination register, and buffers up to two results in a skid buffer so the register-file write port can apply back-pressure without losing data. Presents the oldest pending result to the register file, and exposes it for forwarding back to execute.

## Interface
Parameters:
- BUS_WIDTH, 32, data path width
- REGISTER, 6, register-index width
- DEPTH, 2, buffer entries (fixed at 2; other values unsupported)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- ValidE  in  1  execute result valid this cycle
- ReadyE  out  1  buffer can accept; transfer when ValidE && ReadyE
- FlushE  in  1  discard all buffered and incoming results
- RegWriteE  in  1  result writes the register file
- MemtoRegE  in  1  1: result = ReadDataE; 0: result = ALUOutE
- RegDstE  in  1  1: dest = RdE; 0: dest = RtE
- RtE, RdE  in  REGISTER  candidate destination indices
- ALUOutE, ReadDataE  in  BUS_WIDTH  ALU2 result / memory read data
- ValidW  out  1  head entry pending write
- ReadyW  in  1  register-file write port free; pop when ValidW && ReadyW
- WriteRegW  out  REGISTER  head destination index
- ResultW  out  BUS_WIDTH  head write data
- Occupancy  out  2  entries held (0..2)

## Operation
- States: EMPTY (0 entries), ONE (1), FULL (2); Occupancy encodes state.
- Push (ValidE && ReadyE && !FlushE): entry = {WriteReg = RegDstE ? RdE : RtE, Result = MemtoRegE ? ReadDataE : ALUOutE}, computed at capture.
- Push with RegWriteE=0: handshake completes, nothing stored, Occupancy unchanged.
- Pop (ValidW && ReadyW): head retired; second entry becomes head same edge.
- Transitions: EMPTY -push-> ONE; ONE -push,no pop-> FULL; ONE -pop,no push-> EMPTY; ONE -push+pop-> ONE (new entry becomes head); FULL -pop-> ONE; otherwise hold.
- ReadyE = (Occupancy < 2) && !RST. In FULL no push occurs even if a pop occurs that cycle (no combinational ready-from-pop path).
- FlushE: next edge Occupancy = 0, ValidW = 0; a same-cycle push is dropped; a same-cycle pop is irrelevant (entry discarded either way). Flush in EMPTY is a no-op.
- Order strictly FIFO; entries never reordered or duplicated.
- Entries retain stale data when invalid; WriteRegW/ResultW only meaningful while ValidW=1.

## Timing
- Reset (RST high at edge): Occupancy=0, ValidW=0, WriteRegW=0, ResultW=0, storage cleared; ReadyE=0 while RST high, 1 first cycle after release.
- RST overrides FlushE, push and pop in the same cycle; reset mid-operation drops all entries.
- Latency: push at edge N -> ValidW=1 with that entry from cycle N+1; minimum one cycle E-to-W, no combinational pass-through.
- Throughput: one result per cycle sustained while ReadyW=1.
- ValidW, WriteRegW, ResultW, Occupancy registered; ReadyE depends only on registered state and RST.
- Once ValidW=1, head WriteRegW/ResultW stay stable until popped or flushed.

## Structure
- Shared package: BUS_WIDTH, REGISTER constants; occupancy state enum (EMPTY/ONE/FULL); entry struct {WriteReg, Result}.
- Sub-module wb_fifo2: generic 2-entry FIFO (push/pop/flush/count) holding the entry struct; ex_wb_reg adds writeback muxing, RegWrite filtering, handshake.

## Test plan
- Reset then single push {RegDstE=1, RdE=5, RtE=9, MemtoRegE=0, ALUOutE=0x1234}, ReadyW=1 -> next cycle ValidW=1, WriteRegW=5, ResultW=0x1234; following cycle ValidW=0.
- ReadyW=0, push A (MemtoReg=1, ReadData=0xAAAA) then B -> Occupancy=2, ReadyE=0, third ValidE ignored; ReadyW=1 -> A then B in order.
- FULL, ReadyW=1 and ValidE=1 same cycle -> one pop, no push; Occupancy 2->1; ReadyE=1 next cycle.
- Push with RegWriteE=0 -> ReadyE handshake completes, Occupancy stays 0, ValidW stays 0.
- Occupancy=2, FlushE=1 with ValidE=1 -> next cycle Occupancy=0, ValidW=0, incoming entry absent.
- RST asserted with Occupancy=1 and ValidE=1 -> next cycle all outputs 0, ReadyE=0 during RST, 1 after release.
